fetch_ctrl: RTL and testbench

//  Instruction-fetch sequencer that reads the 8-bit program ROM (drives adrs/rd, samples dout).

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_ctrl.sv | 162 ++++++++++++++++
 tb/tb_fetch_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch sequencer.
package fetch_pkg;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 8;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    VLD  = 2'd2,
    HALT = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns pc, runs ROM read timing, hands bytes to the decoder.
// Optional bounds checking against PROG_LAST is enabled with `define FETCH_BOUNDS_EN.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int              AW        = AW_DEF,
  parameter int              DW        = DW_DEF,
  parameter int              WAIT_CYC  = 0,
  parameter logic [AW-1:0]   RESET_PC  = 8'h00,
  parameter logic [AW-1:0]   PROG_LAST = 8'h0D
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          halt,
  input  logic          jmp_en,
  input  logic [AW-1:0] jmp_adrs,
  output logic [AW-1:0] adrs,
  output logic          rd,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] ir,
  output logic [AW-1:0] ir_adrs,
  output logic          ir_valid,
  input  logic          ir_ready,
  output logic          busy,
  output logic          fault
);

  localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0]    PC_ONE  = {{(AW-1){1'b0}}, 1'b1};

  fetch_state_e     state_r, state_d;
  logic [AW-1:0]    pc_r, pc_d;
  logic [CNT_W-1:0] cnt_r, cnt_d;
  logic [DW-1:0]    ir_r, ir_d;
  logic [AW-1:0]    ir_adrs_r, ir_adrs_d;
  logic             halt_req_r, halt_req_d;
  logic             fault_r, fault_d;
  logic             rd_r, busy_r, ir_valid_r;
  logic             oob_cur_s, oob_nxt_s;

`ifdef FETCH_BOUNDS_EN
  assign oob_cur_s = (pc_r > PROG_LAST);
  assign oob_nxt_s = (pc_d > PROG_LAST);
`else
  logic unused_prog_last_s;
  assign unused_prog_last_s = ^PROG_LAST;
  assign oob_cur_s = 1'b0;
  assign oob_nxt_s = 1'b0;
`endif

  // Next-state, pc, counter and capture logic.
  always_comb begin
    state_d    = state_r;
    pc_d       = pc_r;
    cnt_d      = cnt_r;
    ir_d       = ir_r;
    ir_adrs_d  = ir_adrs_r;
    halt_req_d = halt_req_r;
    fault_d    = fault_r;
    case (state_r)
      IDLE, HALT: begin
        if (jmp_en) begin
          pc_d = jmp_adrs;
        end else begin
          pc_d = pc_r;
        end
        if (start) begin
          state_d    = RD;
          cnt_d      = WAIT_LD;
          halt_req_d = 1'b0;
          fault_d    = 1'b0;
        end else begin
          state_d = state_r;
        end
      end
      RD: begin
        if (halt) begin
          halt_req_d = 1'b1;
        end else begin
          halt_req_d = halt_req_r;
        end
        // A jump restarts the read; an out-of-range pc never reaches the ROM.
        if (jmp_en) begin
          pc_d  = jmp_adrs;
          cnt_d = WAIT_LD;
        end else if (oob_cur_s) begin
          fault_d = 1'b1;
          state_d = HALT;
        end else if (cnt_r != {CNT_W{1'b0}}) begin
          cnt_d = cnt_r - CNT_ONE;
        end else begin
          ir_d      = din;
          ir_adrs_d = pc_r;
          pc_d      = pc_r + PC_ONE;
          state_d   = VLD;
        end
      end
      VLD: begin
        if (halt) begin
          halt_req_d = 1'b1;
        end else begin
          halt_req_d = halt_req_r;
        end
        if (jmp_en) begin
          pc_d    = jmp_adrs;
          cnt_d   = WAIT_LD;
          state_d = RD;
        end else if (ir_ready) begin
          if (halt_req_r || halt) begin
            state_d = HALT;
          end else begin
            state_d = RD;
            cnt_d   = WAIT_LD;
          end
        end else begin
          state_d = VLD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and registered output flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      pc_r       <= RESET_PC;
      cnt_r      <= {CNT_W{1'b0}};
      ir_r       <= {DW{1'b0}};
      ir_adrs_r  <= {AW{1'b0}};
      halt_req_r <= 1'b0;
      fault_r    <= 1'b0;
      rd_r       <= 1'b0;
      busy_r     <= 1'b0;
      ir_valid_r <= 1'b0;
    end else begin
      state_r    <= state_d;
      pc_r       <= pc_d;
      cnt_r      <= cnt_d;
      ir_r       <= ir_d;
      ir_adrs_r  <= ir_adrs_d;
      halt_req_r <= halt_req_d;
      fault_r    <= fault_d;
      rd_r       <= (state_d == RD) && !oob_nxt_s;
      busy_r     <= (state_d == RD) || (state_d == VLD);
      ir_valid_r <= (state_d == VLD);
    end
  end

  assign adrs     = pc_r;
  assign rd       = rd_r;
  assign ir       = ir_r;
  assign ir_adrs  = ir_adrs_r;
  assign ir_valid = ir_valid_r;
  assign busy     = busy_r;
  assign fault    = fault_r;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl: one instance with WAIT_CYC=0, one with WAIT_CYC=3.
module tb_fetch_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, halt, jmp_en, ir_ready;
  logic [7:0] jmp_adrs, adrs, din, ir, ir_adrs;
  logic       rd, ir_valid, busy, fault;

  logic       rst_b, start_b, ready_b;
  logic [7:0] adrs_b, din_b, ir_b, ir_adrs_b;
  logic       rd_b, ir_valid_b, busy_b, fault_b;

  int checks = 0;
  int failures = 0;
  int hs_cnt = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] rom(input logic [7:0] a);
    case (a)
      8'h00:   return 8'h01;
      8'h01:   return 8'h20;
      8'h02:   return 8'h05;
      8'h03:   return 8'h22;
      8'h0C:   return 8'h06;
      8'h0D:   return 8'h02;
      default: return a ^ 8'hFF;
    endcase
  endfunction

  assign din   = rom(adrs);
  assign din_b = rom(adrs_b);

  fetch_ctrl #(.WAIT_CYC(0)) dut (
    .clk(clk), .rst(rst), .start(start), .halt(halt), .jmp_en(jmp_en),
    .jmp_adrs(jmp_adrs), .adrs(adrs), .rd(rd), .din(din), .ir(ir),
    .ir_adrs(ir_adrs), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .busy(busy), .fault(fault)
  );

  fetch_ctrl #(.WAIT_CYC(3)) dut_b (
    .clk(clk), .rst(rst_b), .start(start_b), .halt(1'b0), .jmp_en(1'b0),
    .jmp_adrs(8'h00), .adrs(adrs_b), .rd(rd_b), .din(din_b), .ir(ir_b),
    .ir_adrs(ir_adrs_b), .ir_valid(ir_valid_b), .ir_ready(ready_b),
    .busy(busy_b), .fault(fault_b)
  );

  // Counts decoder handshakes on the WAIT_CYC=0 instance.
  always @(posedge clk) begin
    if (!rst && ir_valid && ir_ready) hs_cnt <= hs_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; halt = 1'b0; jmp_en = 1'b0; jmp_adrs = 8'h00; ir_ready = 1'b0;
    rst_b = 1'b1; start_b = 1'b0; ready_b = 1'b1;
    tick(); tick();
    chk("rst_rd", rd, 1'b0); chk("rst_busy", busy, 1'b0); chk("rst_valid", ir_valid, 1'b0);
    chk("rst_ir", ir, 8'h00); chk("rst_ir_adrs", ir_adrs, 8'h00); chk("rst_adrs", adrs, 8'h00);
    chk("rst_fault", fault, 1'b0); chk("rst_b_rd", rd_b, 1'b0); chk("rst_b_valid", ir_valid_b, 1'b0);

    // 1: streaming fetch, one byte every 2 cycles
    rst = 1'b0; rst_b = 1'b0; ir_ready = 1'b1; start = 1'b1;
    tick();
    chk("s1_rd", rd, 1'b1); chk("s1_busy", busy, 1'b1); chk("s1_adrs", adrs, 8'h00);
    chk("s1_valid0", ir_valid, 1'b0);
    start = 1'b0;
    tick();
    chk("s1_ir0", ir, 8'h01); chk("s1_ira0", ir_adrs, 8'h00); chk("s1_v0", ir_valid, 1'b1);
    chk("s1_rd_vld", rd, 1'b0);
    tick();
    chk("s1_rd1", rd, 1'b1); chk("s1_adrs1", adrs, 8'h01);
    tick();
    chk("s1_ir1", ir, 8'h20); chk("s1_ira1", ir_adrs, 8'h01);
    tick();
    chk("s1_adrs2", adrs, 8'h02);
    ir_ready = 1'b0;

    // 2: decoder stall holds the byte
    tick();
    chk("s2_ir", ir, 8'h05); chk("s2_ira", ir_adrs, 8'h02);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("s2_hold_ir", ir, 8'h05); chk("s2_hold_rd", rd, 1'b0);
      chk("s2_hold_pc", adrs, 8'h03); chk("s2_hold_v", ir_valid, 1'b1);
    end
    ir_ready = 1'b1;
    tick();
    chk("s2_rd", rd, 1'b1); chk("s2_vdrop", ir_valid, 1'b0);
    tick();
    chk("s2_ir_next", ir, 8'h22); chk("s2_ira_next", ir_adrs, 8'h03);
    tick();
    chk("s3_rd_at4", adrs, 8'h04);

    // 3: jump during RD aborts the read of 04
    jmp_en = 1'b1; jmp_adrs = 8'h0C;
    tick();
    chk("s3_adrs", adrs, 8'h0C); chk("s3_ir_keep", ir, 8'h22);
    chk("s3_valid", ir_valid, 1'b0); chk("s3_rd", rd, 1'b1);
    jmp_en = 1'b0;
    tick();
    chk("s3_ir0c", ir, 8'h06); chk("s3_ira0c", ir_adrs, 8'h0C);
    tick(); tick();
    chk("s3_ir0d", ir, 8'h02); chk("s3_ira0d", ir_adrs, 8'h0D);

    // 4: jump coincident with handshake
    jmp_en = 1'b1; jmp_adrs = 8'h02;
    tick();
    chk("s4_hs", hs_cnt, 6); chk("s4_vdrop", ir_valid, 1'b0);
    chk("s4_adrs", adrs, 8'h02); chk("s4_rd", rd, 1'b1);
    jmp_en = 1'b0;
    tick();
    chk("s4_ir", ir, 8'h05); chk("s4_ira", ir_adrs, 8'h02);

    // 5: halt during RD
    tick();
    chk("s5_rd", rd, 1'b1);
    halt = 1'b1;
    tick();
    chk("s5_ir", ir, 8'h22); chk("s5_v", ir_valid, 1'b1);
    halt = 1'b0;
    tick();
    chk("s5_busy", busy, 1'b0); chk("s5_valid", ir_valid, 1'b0);
    chk("s5_rd0", rd, 1'b0); chk("s5_pc", adrs, 8'h04);
    tick();
    chk("s5_stay", busy, 1'b0);
    start = 1'b1;
    tick();
    chk("s5_rdres", rd, 1'b1); chk("s5_adrsres", adrs, 8'h04);
    start = 1'b0;
    tick();
    chk("s5_irres", ir, 8'hFB); chk("s5_irares", ir_adrs, 8'h04);

    // 6: pc boundary
`ifdef FETCH_BOUNDS_EN
    jmp_en = 1'b1; jmp_adrs = 8'h0E;
    tick();
    chk("s6_rd_low", rd, 1'b0); chk("s6_adrs", adrs, 8'h0E);
    jmp_en = 1'b0;
    tick();
    chk("s6_fault", fault, 1'b1); chk("s6_busy", busy, 1'b0); chk("s6_rd", rd, 1'b0);
    tick();
    chk("s6_sticky", fault, 1'b1);
`else
    jmp_en = 1'b1; jmp_adrs = 8'hFF;
    tick();
    chk("s6_adrs", adrs, 8'hFF); chk("s6_rd", rd, 1'b1);
    jmp_en = 1'b0;
    tick();
    chk("s6_irff", ir, 8'h00); chk("s6_iraff", ir_adrs, 8'hFF); chk("s6_wrap", adrs, 8'h00);
    tick(); tick();
    chk("s6_ir00", ir, 8'h01); chk("s6_ira00", ir_adrs, 8'h00); chk("s6_fault0", fault, 1'b0);
`endif

    // 7: WAIT_CYC=3 timing, then reset mid-RD
    start_b = 1'b1;
    tick();
    chk("s7_rd_t1", rd_b, 1'b1); chk("s7_adrs", adrs_b, 8'h00);
    start_b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("s7_rd_wait", rd_b, 1'b1); chk("s7_v_wait", ir_valid_b, 1'b0);
    end
    tick();
    chk("s7_valid", ir_valid_b, 1'b1); chk("s7_ir", ir_b, 8'h01); chk("s7_rd_off", rd_b, 1'b0);
    tick();
    chk("s7_rd2", rd_b, 1'b1); chk("s7_adrs2", adrs_b, 8'h01);
    tick();
    chk("s7_mid", rd_b, 1'b1);
    rst_b = 1'b1;
    tick();
    chk("s7_rst_rd", rd_b, 1'b0); chk("s7_rst_busy", busy_b, 1'b0);
    chk("s7_rst_v", ir_valid_b, 1'b0); chk("s7_rst_ir", ir_b, 8'h00);
    chk("s7_rst_ira", ir_adrs_b, 8'h00); chk("s7_rst_pc", adrs_b, 8'h00);
    chk("s7_rst_fault", fault_b, 1'b0);
    rst_b = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
